// File: rtl/icb_copy_dma_pkg.sv
// icb_copy_dma_pkg
// Shared widths, the copy-engine state encoding and a small address helper.
// These are used by icb_copy_dma and by anything that observes its debug state.
package icb_copy_dma_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  localparam logic [3:0] WMASK_ALL  = 4'hF;
  localparam logic [3:0] WMASK_NONE = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_CMD = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_CMD = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Clears the byte-offset bits; ICB transfers here are whole 32-bit words.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icb_copy_dma.sv
// icb_copy_dma
// Word-copy engine acting as a second ICB initiator. A start pulse in IDLE
// latches source, destination and word count; the engine then performs
// read-command / read-response / write-command for each word and pulses done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle job request (only honoured in IDLE)
//   src_addr, dst_addr  byte addresses, low two bits ignored
//   len_words           words to copy, 0 allowed
//   busy, done, err     status: busy while transferring, done pulse, sticky read error
//   m_icb_cmd_*         ICB command channel (master side)
//   m_icb_rsp_*         ICB response channel (master side, always ready)
//   dbg_state_o         current FSM state, for observation only
//
// Handshake: a command transfers on a rising clk edge where
// m_icb_cmd_valid and m_icb_cmd_ready are both high. Once valid is raised,
// valid and every command field stay constant until that transfer. A response
// transfers on any edge with m_icb_rsp_valid high (rsp_ready is tied high);
// only a response seen in RD_RSP is used.
module icb_copy_dma
  import icb_copy_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_icb_cmd_valid,
  input  logic              m_icb_cmd_ready,
  output logic [ADDR_W-1:0] m_icb_cmd_addr,
  output logic              m_icb_cmd_read,
  output logic [DATA_W-1:0] m_icb_cmd_wdata,
  output logic [3:0]        m_icb_cmd_wmask,
  input  logic              m_icb_rsp_valid,
  output logic              m_icb_rsp_ready,
  input  logic              m_icb_rsp_err,
  input  logic [DATA_W-1:0] m_icb_rsp_rdata,
  output logic [2:0]        dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Command fields come only from state and registers, so they cannot move
  // while a command is stalled by cmd_ready.
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    err_d           = err_q;
    m_icb_cmd_valid = 1'b0;
    m_icb_cmd_read  = 1'b0;
    m_icb_cmd_addr  = '0;
    m_icb_cmd_wdata = '0;
    m_icb_cmd_wmask = WMASK_NONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = word_align(src_addr);
          dst_d   = word_align(dst_addr);
          cnt_d   = len_words;
          err_d   = 1'b0;
          state_d = (len_words == '0) ? ST_DONE : ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        m_icb_cmd_valid = 1'b1;
        m_icb_cmd_read  = 1'b1;
        m_icb_cmd_addr  = src_q;
        if (m_icb_cmd_ready) state_d = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        if (m_icb_rsp_valid) begin
          if (m_icb_rsp_err) begin
            // Failed read aborts the job; the word is never written.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            data_d  = m_icb_rsp_rdata;
            state_d = ST_WR_CMD;
          end
        end
      end
      ST_WR_CMD: begin
        m_icb_cmd_valid = 1'b1;
        m_icb_cmd_addr  = dst_q;
        m_icb_cmd_wdata = data_q;
        m_icb_cmd_wmask = WMASK_ALL;
        if (m_icb_cmd_ready) begin
          // Write is considered complete at command acceptance.
          src_d   = src_q + ADDR_W'(4);
          dst_d   = dst_q + ADDR_W'(4);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_RD_CMD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy            = (state_q == ST_RD_CMD) || (state_q == ST_RD_RSP) ||
                           (state_q == ST_WR_CMD);
  assign done            = (state_q == ST_DONE);
  assign err             = err_q;
  assign m_icb_rsp_ready = 1'b1;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_icb_copy_dma.sv
// tb_icb_copy_dma
// Drives icb_copy_dma against a behavioural ICB memory slave. Each job's
// expected command stream is built from the copy rules on a private copy of
// the memory and checked at every command handshake; completion time is
// derived from the number of transfers plus the stall/latency cycles the
// slave chose to insert.
module tb_icb_copy_dma;
  import icb_copy_dma_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len_words = '0;
  logic              busy, done, err;
  logic              m_icb_cmd_valid;
  logic              m_icb_cmd_ready;
  logic [ADDR_W-1:0] m_icb_cmd_addr;
  logic              m_icb_cmd_read;
  logic [DATA_W-1:0] m_icb_cmd_wdata;
  logic [3:0]        m_icb_cmd_wmask;
  logic              m_icb_rsp_valid;
  logic              m_icb_rsp_ready;
  logic              m_icb_rsp_err;
  logic [DATA_W-1:0] m_icb_rsp_rdata;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  icb_copy_dma dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len_words       (len_words),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .m_icb_cmd_valid (m_icb_cmd_valid),
    .m_icb_cmd_ready (m_icb_cmd_ready),
    .m_icb_cmd_addr  (m_icb_cmd_addr),
    .m_icb_cmd_read  (m_icb_cmd_read),
    .m_icb_cmd_wdata (m_icb_cmd_wdata),
    .m_icb_cmd_wmask (m_icb_cmd_wmask),
    .m_icb_rsp_valid (m_icb_rsp_valid),
    .m_icb_rsp_ready (m_icb_rsp_ready),
    .m_icb_rsp_err   (m_icb_rsp_err),
    .m_icb_rsp_rdata (m_icb_rsp_rdata),
    .dbg_state_o     (dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard entry: {read, addr[31:0], wdata[31:0]}
  logic [64:0] exp_q[$];

  // Memory slave state and knobs
  logic [31:0] mem[logic [31:0]];
  int          cfg_stall = 0;   // <0: random 0..3 per command
  int          cfg_lat   = 0;   // <0: random 0..2 per read
  bit          cfg_noise = 1'b0;
  int          err_read  = 0;   // 1-based read index answered with rsp_err
  int          rd_seen   = 0;
  int          wr_seen   = 0;
  int          extra     = 0;   // wait cycles the slave inserted this job
  logic [31:0] rd_log[$];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Reference: sequential word copy on a private memory snapshot.
  task automatic model_job(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input int e_rd,
                           output int reads, output int writes);
    logic [31:0] mm[logic [31:0]];
    logic [31:0] s, d, v;
    mm = mem;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    reads = 0;
    writes = 0;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({1'b1, s, 32'h0});
      reads++;
      if (reads == e_rd) break;
      v = mm.exists(s) ? mm[s] : mem_default(s);
      exp_q.push_back({1'b0, d, v});
      writes++;
      mm[d] = v;
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // ICB memory slave
  initial begin
    bit          new_cmd;
    int          stall_left;
    bit          rsp_due;
    int          rsp_delay;
    logic [31:0] rsp_addr;
    new_cmd = 1'b1; stall_left = 0; rsp_due = 1'b0; rsp_delay = 0; rsp_addr = '0;
    m_icb_cmd_ready = 1'b0;
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_err   = 1'b0;
    m_icb_rsp_rdata = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        new_cmd = 1'b1; stall_left = 0; rsp_due = 1'b0;
        m_icb_cmd_ready = 1'b0;
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_err   = 1'b0;
        continue;
      end
      m_icb_rsp_valid = 1'b0;
      m_icb_rsp_err   = 1'b0;
      m_icb_rsp_rdata = '0;
      if (rsp_due) begin
        if (rsp_delay > 0) rsp_delay--;
        else begin
          rd_seen++;
          m_icb_rsp_valid = 1'b1;
          m_icb_rsp_rdata = mem.exists(rsp_addr) ? mem[rsp_addr] : mem_default(rsp_addr);
          m_icb_rsp_err   = (rd_seen == err_read);
          rsp_due = 1'b0;
        end
      end else if (cfg_noise && $urandom_range(0, 7) == 0) begin
        m_icb_rsp_valid = 1'b1;
        m_icb_rsp_err   = 1'($urandom_range(0, 1));
        m_icb_rsp_rdata = $urandom;
      end
      m_icb_cmd_ready = 1'b0;
      if (m_icb_cmd_valid) begin
        if (new_cmd) begin
          stall_left = (cfg_stall < 0) ? $urandom_range(0, 3) : cfg_stall;
          extra += stall_left;
          new_cmd = 1'b0;
        end
        if (stall_left > 0) stall_left--;
        else begin
          m_icb_cmd_ready = 1'b1;
          new_cmd = 1'b1;
          if (m_icb_cmd_read) begin
            rd_log.push_back(m_icb_cmd_addr);
            rsp_due   = 1'b1;
            rsp_addr  = m_icb_cmd_addr;
            rsp_delay = (cfg_lat < 0) ? $urandom_range(0, 2) : cfg_lat;
            extra += rsp_delay;
          end else begin
            mem[m_icb_cmd_addr] = m_icb_cmd_wdata;
            wr_seen++;
          end
        end
      end
    end
  end

  // Per-cycle compare process
  initial begin
    logic        pv;
    logic [31:0] pa, pw;
    logic        pr;
    logic [3:0]  pm;
    logic [64:0] e;
    pv = 1'b0; pa = '0; pw = '0; pr = 1'b0; pm = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      check("rsp_ready", m_icb_rsp_ready, 1);
      if (pv) begin
        check("stall_valid", m_icb_cmd_valid, 1);
        check("stall_addr", m_icb_cmd_addr, pa);
        check("stall_read", m_icb_cmd_read, pr);
        check("stall_wdata", m_icb_cmd_wdata, pw);
        check("stall_wmask", m_icb_cmd_wmask, pm);
      end
      if (!m_icb_cmd_valid) begin
        check("idle_addr", m_icb_cmd_addr, 0);
        check("idle_fields", {m_icb_cmd_read, m_icb_cmd_wmask, m_icb_cmd_wdata}, 0);
      end else begin
        check("cmd_wmask", m_icb_cmd_wmask, m_icb_cmd_read ? 4'h0 : 4'hF);
        check("busy_with_cmd", busy, 1);
      end
      if (m_icb_cmd_valid && m_icb_cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_cmd: got addr 0x%0h read %0b, expected no command",
                   m_icb_cmd_addr, m_icb_cmd_read);
        end else begin
          e = exp_q.pop_front();
          check("cmd_read", m_icb_cmd_read, e[64]);
          check("cmd_addr", m_icb_cmd_addr, e[63:32]);
          if (!e[64]) check("cmd_wdata", m_icb_cmd_wdata, e[31:0]);
        end
      end
      pv = m_icb_cmd_valid && !m_icb_cmd_ready;
      pa = m_icb_cmd_addr; pr = m_icb_cmd_read; pw = m_icb_cmd_wdata; pm = m_icb_cmd_wmask;
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len, input int e_rd,
                         input bit noise_start, output int done_cyc);
    int reads, writes, busy_cnt;
    bit exp_err;
    model_job(src, dst, len, e_rd, reads, writes);
    exp_err  = (e_rd >= 1) && (e_rd <= int'(len));
    err_read = e_rd; rd_seen = 0; wr_seen = 0; extra = 0;
    rd_log.delete();
    @(posedge clk); #1;
    start = 1'b1; src_addr = src; dst_addr = dst; len_words = len;
    @(posedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len_words = 16'($urandom);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) check("err_cleared_on_start", err, 0);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (busy) busy_cnt++;
      if (noise_start) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done within 400 cycles, expected a done pulse");
      pulse_reset();
    end else begin
      check("done_cycle", done_cyc, 1 + 2 * reads + writes + extra);
      check("busy_cycles", busy_cnt, done_cyc - 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("err_after_job", err, exp_err);
      check("writes_issued", wr_seen, writes);
      check("exp_q_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    int dc, r, w, n;
    logic [31:0] s, d;
    logic [15:0] l;
    int e;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_valid", m_icb_cmd_valid, 0);
    check("rst_cmd_addr", m_icb_cmd_addr, 0);
    check("rst_cmd_fields", {m_icb_cmd_read, m_icb_cmd_wmask, m_icb_cmd_wdata}, 0);
    check("rst_rsp_ready", m_icb_rsp_ready, 1);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4-word copy, no stalls
    for (int k = 0; k < 4; k++) mem[32'(4 * k)] = 32'h1111_1111 * (k + 1);
    cfg_stall = 0; cfg_lat = 0; cfg_noise = 1'b0;
    run_job(32'h0, 32'h100, 16'd4, 0, 1'b0, dc);
    check("t1_done_at_13", dc, 13);
    check("t1_dst0", mem[32'h100], 32'h1111_1111);
    check("t1_dst1", mem[32'h104], 32'h2222_2222);
    check("t1_dst2", mem[32'h108], 32'h3333_3333);
    check("t1_dst3", mem[32'h10C], 32'h4444_4444);
    check("t1_err", err, 0);

    // Zero-length job
    run_job(32'h40, 32'h80, 16'd0, 0, 1'b0, dc);
    check("t2_done_at_1", dc, 1);
    check("t2_no_reads", rd_log.size(), 0);

    // 3-cycle command stall, 2 words, unaligned inputs
    cfg_stall = 3;
    run_job(32'h203, 32'h302, 16'd2, 0, 1'b0, dc);
    check("t3_done_at_19", dc, 19);
    check("t3_rd0", rd_log[0], 32'h200);
    cfg_stall = 0;

    // Error on the second read of a 3-word job, then a clean job
    run_job(32'h400, 32'h500, 16'd3, 2, 1'b0, dc);
    check("t4_one_write", wr_seen, 1);
    check("t4_err_set", err, 1);
    check("t4_done_at_6", dc, 6);
    run_job(32'h404, 32'h504, 16'd1, 0, 1'b0, dc);
    check("t4_err_cleared", err, 0);

    // Source address wrap
    run_job(32'hFFFF_FFFC, 32'h600, 16'd2, 0, 1'b0, dc);
    check("t5_rd_count", rd_log.size(), 2);
    check("t5_rd0", rd_log[0], 32'hFFFF_FFFC);
    check("t5_rd1", rd_log[1], 32'h0000_0000);

    // Reset asserted while a write command is stalled
    cfg_stall = 3;
    model_job(32'h700, 32'h800, 16'd3, 0, r, w);
    err_read = 0; rd_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h700; dst_addr = 32'h800; len_words = 16'd3;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(m_icb_cmd_valid && !m_icb_cmd_read) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_wr_cmd", m_icb_cmd_valid && !m_icb_cmd_read, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid_drop", m_icb_cmd_valid, 0);
    check("t6_busy_drop", busy, 0);
    check("t6_no_done", done, 0);
    repeat (2) begin
      @(negedge clk);
      check("t6_no_done_in_reset", done, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_done_after", done, 0);
    check("t6_not_copied", mem.exists(32'h800), 0);
    cfg_stall = 0;
    run_job(32'h700, 32'h800, 16'd3, 0, 1'b0, dc);
    check("t6_rerun_done_at_10", dc, 10);

    // Randomized jobs
    cfg_stall = -1; cfg_lat = -1; cfg_noise = 1'b1;
    for (int j = 0; j < 30; j++) begin
      l = 16'($urandom_range(0, 6));
      s = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      d = ($urandom_range(0, 3) == 0) ? s + 32'(4 * $urandom_range(0, 2)) : $urandom;
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(l) + 1) : 0;
      run_job(s, d, l, e, 1'b1, dc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
